// File: rtl/psum_accum_if.sv
// Stream bundle around the partial-sum accumulator: psum beats in, saturated group sums out.
// The slave modport faces the accumulator and the master modport faces the surrounding logic.
interface psum_accum_if #(
  parameter int IN_W  = 32,
  parameter int LEN_W = 8,
  parameter int OUT_W = 32
);
  logic             clear;
  logic [LEN_W-1:0] cfg_len;
  logic [IN_W-1:0]  psum_in;
  logic             psum_valid;
  logic             psum_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_sat;
  logic             out_valid;
  logic             out_ready;

  modport slave (
    input  clear, cfg_len, psum_in, psum_valid, out_ready,
    output psum_ready, out_data, out_sat, out_valid
  );

  modport master (
    output clear, cfg_len, psum_in, psum_valid, out_ready,
    input  psum_ready, out_data, out_sat, out_valid
  );
endinterface

// File: rtl/psum_accum.sv
// Sums a programmable number of consecutive signed partial sums into one saturated result,
// with a valid/ready output that back-pressures only the beat which would close a group.
module psum_accum #(
  parameter int IN_W  = 32,
  parameter int LEN_W = 8,
  parameter int ACC_W = 40,
  parameter int OUT_W = 32
) (
  input logic           clock,
  input logic           rst_n,
  psum_accum_if.slave   bus
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  state_t                   state;
  logic signed [ACC_W-1:0]  acc;
  logic [LEN_W-1:0]         cnt;
  logic [LEN_W-1:0]         len_q;
  logic [OUT_W-1:0]         out_data_q;
  logic                     out_sat_q;
  logic                     out_valid_q;

  logic [LEN_W-1:0]         eff_len;
  logic                     last;
  logic                     ready;
  logic                     accept;
  logic signed [ACC_W-1:0]  psum_ext;
  logic signed [ACC_W-1:0]  sum;
  logic                     over;
  logic                     under;
  logic [OUT_W-1:0]         sat_val;

  always_comb begin
    eff_len  = (bus.cfg_len == '0) ? LEN_W'(1) : bus.cfg_len;
    last     = (state == IDLE) ? (eff_len == LEN_W'(1)) : (cnt == len_q - LEN_W'(1));
    // Only a group-closing beat has to wait for the previous result to drain.
    ready    = ~(out_valid_q & ~bus.out_ready) | ~last;
    accept   = bus.psum_valid & ready;
    psum_ext = {{(ACC_W-IN_W){bus.psum_in[IN_W-1]}}, bus.psum_in};
    sum      = ((state == IDLE) ? '0 : acc) + psum_ext;
    over     = sum > SAT_MAX;
    under    = sum < SAT_MIN;
    if (over)
      sat_val = SAT_MAX[OUT_W-1:0];
    else if (under)
      sat_val = SAT_MIN[OUT_W-1:0];
    else
      sat_val = sum[OUT_W-1:0];
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      len_q       <= '0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (bus.clear) begin
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      out_valid_q <= 1'b0;
      out_sat_q   <= 1'b0;
    end else begin
      if (out_valid_q && bus.out_ready)
        out_valid_q <= 1'b0;
      // A closing beat overrides the drain above so back-to-back results have no bubble.
      if (accept) begin
        if (last) begin
          out_data_q  <= sat_val;
          out_sat_q   <= over | under;
          out_valid_q <= 1'b1;
          acc         <= '0;
          cnt         <= '0;
          state       <= IDLE;
        end else if (state == IDLE) begin
          len_q <= eff_len;
          acc   <= psum_ext;
          cnt   <= LEN_W'(1);
          state <= RUN;
        end else begin
          acc <= sum;
          cnt <= cnt + LEN_W'(1);
        end
      end
    end
  end

  assign bus.psum_ready = ready;
  assign bus.out_data   = out_data_q;
  assign bus.out_sat    = out_sat_q;
  assign bus.out_valid  = out_valid_q;

endmodule
